// File: rtl/anton_neopixel_decoder_if.sv
// Pixel-buffer write port and frame status of the NeoPixel receive decoder.
// The decoder drives the bus (master); the pixel buffer / status logic consumes it (slave).
interface anton_neopixel_decoder_if #(
  parameter int BUFFER_BITS = 8
);
  logic [BUFFER_BITS-1:0] pixelAddr;
  logic [7:0]             pixelData;
  logic                   pixelWrite;
  logic                   frameDone;
  logic [BUFFER_BITS-1:0] pixelCount;
  logic                   glitchErr;
  logic                   overflowErr;

  modport master (
    output pixelAddr, pixelData, pixelWrite, frameDone, pixelCount, glitchErr, overflowErr
  );

  modport slave (
    input pixelAddr, pixelData, pixelWrite, frameDone, pixelCount, glitchErr, overflowErr
  );
endinterface

// File: rtl/anton_neopixel_decoder.sv
// NeoPixel (WS2812-style) receive decoder: classifies high pulses as '0'/'1', assembles
// 24-bit GRB pixels and writes them into a pixel buffer laid out like the stream TX buffer.
// Optional: define NEOPIXEL_DECODER_GLITCH_FILTER_EN for a 3-sample majority filter
// behind the synchronizer (+2 cycles latency, single-clock spikes removed).
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 255
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module anton_neopixel_decoder #(
  parameter int BUFFER_END    = `BUFFER_END_DEFAULT,
  parameter int ONE_THRESHOLD = 4,
  parameter int MIN_HIGH      = 1,
  parameter int MAX_HIGH      = 7,
  parameter int RESET_CYCLES  = 40
) (
  input  logic clk7mhz,
  input  logic syncReset,
  input  logic neoDataIn,
  input  logic regCtrl32bit,
  input  logic regCtrlRun,
  anton_neopixel_decoder_if.master pixBus
);
  localparam int BUFFER_BITS = `CLOG2(BUFFER_END + 1);
  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(RESET_CYCLES + 1);
  localparam int PW = BUFFER_BITS + 1;
  localparam int AW = PW + 2;

  localparam logic [HW-1:0] MAX_H    = HW'(MAX_HIGH);
  localparam logic [HW-1:0] MIN_H    = HW'(MIN_HIGH);
  localparam logic [HW-1:0] ONE_T    = HW'(ONE_THRESHOLD);
  localparam logic [LW-1:0] LATCH_M1 = LW'(RESET_CYCLES - 1);
  localparam logic [AW-1:0] ADDR_END = AW'(BUFFER_END);

  localparam logic [1:0] WAIT_LATCH = 2'd0;
  localparam logic [1:0] IDLE       = 2'd1;
  localparam logic [1:0] HIGH       = 2'd2;
  localparam logic [1:0] LOW        = 2'd3;

  logic [1:0]             syncReg;
  logic                   lineIn;
  logic [1:0]             state;
  logic [HW-1:0]          highCnt;
  logic [LW-1:0]          lowCnt;
  logic [4:0]             bitIdx;
  logic [21:0]            shiftReg;
  logic [PW-1:0]          pix;
  logic                   mode32;
  logic                   gotBit;
  logic [BUFFER_BITS-1:0] addrReg;
  logic [7:0]             dataReg;
  logic                   writeReg;
  logic                   doneReg;
  logic [BUFFER_BITS-1:0] countReg;
  logic                   glitchReg;
  logic                   overflowReg;

  // Two-flop synchronizer for the asynchronous data pin
  always_ff @(posedge clk7mhz) begin
    if (syncReset) syncReg <= '0;
    else           syncReg <= {syncReg[0], neoDataIn};
  end

`ifdef NEOPIXEL_DECODER_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filtered;

  // 3-sample majority vote: a lone one-clock spike never wins
  always_ff @(posedge clk7mhz) begin
    if (syncReset) begin
      hist     <= '0;
      filtered <= 1'b0;
    end else begin
      hist     <= {hist[0], syncReg[1]};
      filtered <= (syncReg[1] & hist[0]) | (syncReg[1] & hist[1]) | (hist[0] & hist[1]);
    end
  end
  assign lineIn = filtered;
`else
  assign lineIn = syncReg[1];
`endif

  logic            bitVal;
  logic [7:0]      newByte;
  logic [7:0]      packed8;
  logic [PW-1:0]   pixInc;
  logic [PW-1:0]   pixNext;
  logic            wrNeeded;
  logic [AW-1:0]   wrAddr;
  logic [7:0]      wrByte;

  // Bit/byte assembly and buffer address selection for the bit being completed now
  always_comb begin
    bitVal  = (highCnt >= ONE_T);
    newByte = {shiftReg[6:0], bitVal};
    // shiftReg[i] holds wire bit r(22-i) when bit 23 completes
    packed8 = {shiftReg[6], shiftReg[3], shiftReg[21], shiftReg[19],
               shiftReg[17], shiftReg[14], shiftReg[11], shiftReg[9]};
    pixInc  = pix + 1'b1;
    // MSB is sticky so a wrapped pixel counter can never alias back into the buffer
    pixNext = {pix[PW-1] | pixInc[PW-1], pixInc[PW-2:0]};
    wrNeeded = 1'b0;
    wrAddr   = '0;
    wrByte   = newByte;
    if (mode32) begin
      case (bitIdx)
        5'd7:  begin wrNeeded = 1'b1; wrAddr = {pix, 2'b01}; end
        5'd15: begin wrNeeded = 1'b1; wrAddr = {pix, 2'b00}; end
        5'd23: begin wrNeeded = 1'b1; wrAddr = {pix, 2'b10}; end
        default: ;
      endcase
    end else if (bitIdx == 5'd23) begin
      wrNeeded = 1'b1;
      wrAddr   = AW'(pix);
      wrByte   = packed8;
    end
  end

  // Pulse classification FSM, pixel assembly and buffer writes
  always_ff @(posedge clk7mhz) begin
    if (syncReset) begin
      state       <= WAIT_LATCH;
      highCnt     <= '0;
      lowCnt      <= '0;
      bitIdx      <= '0;
      shiftReg    <= '0;
      pix         <= '0;
      mode32      <= 1'b0;
      gotBit      <= 1'b0;
      addrReg     <= '0;
      dataReg     <= '0;
      writeReg    <= 1'b0;
      doneReg     <= 1'b0;
      countReg    <= '0;
      glitchReg   <= 1'b0;
      overflowReg <= 1'b0;
    end else begin
      writeReg <= 1'b0;
      doneReg  <= 1'b0;
      if (!regCtrlRun) begin
        state  <= WAIT_LATCH;
        lowCnt <= '0;
      end else begin
        case (state)
          WAIT_LATCH: begin
            if (lineIn) begin
              lowCnt <= '0;
            end else if (lowCnt == LATCH_M1) begin
              state  <= IDLE;
              lowCnt <= '0;
            end else begin
              lowCnt <= lowCnt + 1'b1;
            end
          end
          IDLE: begin
            if (lineIn) begin
              state       <= HIGH;
              highCnt     <= HW'(1);
              mode32      <= regCtrl32bit;
              glitchReg   <= 1'b0;
              overflowReg <= 1'b0;
              bitIdx      <= '0;
              shiftReg    <= '0;
              pix         <= '0;
              gotBit      <= 1'b0;
            end
          end
          HIGH: begin
            if (lineIn) begin
              // Reaching MAX_HIGH+1 aborts at once, so an over-long pulse never gets to a fall
              if (highCnt == MAX_H) begin
                glitchReg <= 1'b1;
                state     <= WAIT_LATCH;
                lowCnt    <= '0;
              end else begin
                highCnt <= highCnt + 1'b1;
              end
            end else begin
              state  <= LOW;
              lowCnt <= LW'(1);
              if (highCnt < MIN_H) begin
                glitchReg <= 1'b1;
              end else begin
                shiftReg <= {shiftReg[20:0], bitVal};
                gotBit   <= 1'b1;
                if (bitIdx == 5'd23) begin
                  bitIdx <= '0;
                  pix    <= pixNext;
                end else begin
                  bitIdx <= bitIdx + 1'b1;
                end
                if (wrNeeded) begin
                  if (wrAddr > ADDR_END) begin
                    overflowReg <= 1'b1;
                  end else begin
                    writeReg <= 1'b1;
                    addrReg  <= wrAddr[BUFFER_BITS-1:0];
                    dataReg  <= wrByte;
                  end
                end
              end
            end
          end
          default: begin // LOW
            if (lineIn) begin
              state   <= HIGH;
              highCnt <= HW'(1);
            end else if (lowCnt == LATCH_M1) begin
              state <= IDLE;
              if (gotBit) begin
                doneReg  <= 1'b1;
                countReg <= pix[BUFFER_BITS-1:0];
              end
            end else begin
              lowCnt <= lowCnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign pixBus.pixelAddr   = addrReg;
  assign pixBus.pixelData   = dataReg;
  assign pixBus.pixelWrite  = writeReg;
  assign pixBus.frameDone   = doneReg;
  assign pixBus.pixelCount  = countReg;
  assign pixBus.glitchErr   = glitchReg;
  assign pixBus.overflowErr = overflowReg;
endmodule

// File: tb/tb_anton_neopixel_decoder.sv
// Directed bench for anton_neopixel_decoder: a full-size buffer instance plus a
// BUFFER_END=3 instance sharing the same serial line.
module tb_anton_neopixel_decoder;
  logic clk7mhz = 1'b0;
  logic syncReset, neoDataIn, regCtrl32bit, regCtrlRun;
  int   nVec = 0;
  int   nErr = 0;

  always #5 clk7mhz = ~clk7mhz;

  anton_neopixel_decoder_if #(.BUFFER_BITS(8)) bus();
  anton_neopixel_decoder_if #(.BUFFER_BITS(2)) busSmall();

  anton_neopixel_decoder #(.BUFFER_END(255)) dut (
    .clk7mhz(clk7mhz), .syncReset(syncReset), .neoDataIn(neoDataIn),
    .regCtrl32bit(regCtrl32bit), .regCtrlRun(regCtrlRun), .pixBus(bus)
  );

  anton_neopixel_decoder #(.BUFFER_END(3)) dutSmall (
    .clk7mhz(clk7mhz), .syncReset(syncReset), .neoDataIn(neoDataIn),
    .regCtrl32bit(regCtrl32bit), .regCtrlRun(regCtrlRun), .pixBus(busSmall)
  );

  // Write/frame logs, sampled on the falling edge
  logic [7:0] wrAddr[$];
  logic [7:0] wrData[$];
  logic [1:0] sAddr[$];
  logic [7:0] sData[$];
  int         fdCount = 0;
  int         sFdCount = 0;
  logic [7:0] lastCount = '0;
  logic [1:0] sLastCount = '0;

  always @(negedge clk7mhz) begin
    if (bus.pixelWrite) begin
      wrAddr.push_back(bus.pixelAddr);
      wrData.push_back(bus.pixelData);
    end
    if (bus.frameDone) begin
      fdCount++;
      lastCount = bus.pixelCount;
    end
    if (busSmall.pixelWrite) begin
      sAddr.push_back(busSmall.pixelAddr);
      sData.push_back(busSmall.pixelData);
    end
    if (busSmall.frameDone) begin
      sFdCount++;
      sLastCount = busSmall.pixelCount;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk7mhz);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    neoDataIn = v;
    tick(n);
  endtask

  // '1' = 6 high / 3 low, '0' = 2 high / 7 low
  task automatic sendBit(input logic b);
    if (b) begin drive(1'b1, 6); drive(1'b0, 3); end
    else   begin drive(1'b1, 2); drive(1'b0, 7); end
  endtask

  // rv[k] is wire bit r_k, sent k = 0 first
  task automatic sendWire(input logic [23:0] rv, input int nBits);
    for (int k = 0; k < nBits; k++) sendBit(rv[k]);
  endtask

  task automatic latchLow();
    drive(1'b0, 50);
  endtask

  task automatic clearLog();
    wrAddr.delete(); wrData.delete(); sAddr.delete(); sData.delete();
    fdCount = 0; sFdCount = 0;
  endtask

  // Wire vector for a GRB pixel: r0..r7 = G7..G0, r8..r15 = R7..R0, r16..r23 = B7..B0
  function automatic logic [23:0] grbWire(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
    logic [23:0] rv;
    for (int i = 0; i < 8; i++) begin
      rv[i]      = g[7-i];
      rv[8 + i]  = r[7-i];
      rv[16 + i] = b[7-i];
    end
    return rv;
  endfunction

  // Packed byte as the stream TX puts it on the wire; unused wire bits set to 1
  function automatic logic [23:0] packedWire(input logic [7:0] d);
    logic [23:0] rv;
    rv = '1;
    rv[16] = d[7]; rv[19] = d[6]; rv[1]  = d[5]; rv[3]  = d[4];
    rv[5]  = d[3]; rv[8]  = d[2]; rv[11] = d[1]; rv[13] = d[0];
    return rv;
  endfunction

  task automatic test_reset();
    syncReset = 1'b1; neoDataIn = 1'b0; regCtrl32bit = 1'b0; regCtrlRun = 1'b1;
    tick(3);
    nVec++; if (bus.pixelWrite !== 1'b0) begin nErr++; $display("FAIL reset_pixelWrite got %b want 0", bus.pixelWrite); end
    nVec++; if (bus.frameDone !== 1'b0) begin nErr++; $display("FAIL reset_frameDone got %b want 0", bus.frameDone); end
    nVec++; if (bus.pixelAddr !== 8'h00 || bus.pixelData !== 8'h00) begin nErr++; $display("FAIL reset_addrData got %h/%h want 00/00", bus.pixelAddr, bus.pixelData); end
    nVec++; if (bus.pixelCount !== 8'h00) begin nErr++; $display("FAIL reset_pixelCount got %h want 00", bus.pixelCount); end
    nVec++; if (bus.glitchErr !== 1'b0 || bus.overflowErr !== 1'b0) begin nErr++; $display("FAIL reset_errs got %b%b want 00", bus.glitchErr, bus.overflowErr); end
    syncReset = 1'b0;
    clearLog();
    latchLow();
    nVec++; if (fdCount !== 0) begin nErr++; $display("FAIL reset_noFrame got %0d want 0", fdCount); end
  endtask

  task automatic test_loopback8();
    logic [7:0] px [3];
    px[0] = 8'hA5; px[1] = 8'h3C; px[2] = 8'hFF;
    clearLog(); regCtrl32bit = 1'b0;
    for (int p = 0; p < 3; p++) sendWire(packedWire(px[p]), 24);
    latchLow();
    nVec++; if (wrAddr.size() !== 3) begin nErr++; $display("FAIL lb8_writes got %0d want 3", wrAddr.size()); end
    for (int i = 0; i < 3 && i < wrAddr.size(); i++) begin
      nVec++;
      if (wrAddr[i] !== 8'(i) || wrData[i] !== px[i]) begin
        nErr++; $display("FAIL lb8_write%0d got %h:%h want %h:%h", i, wrAddr[i], wrData[i], 8'(i), px[i]);
      end
    end
    nVec++; if (fdCount !== 1 || lastCount !== 8'd3) begin nErr++; $display("FAIL lb8_frame got %0d/%0d want 1/3", fdCount, lastCount); end
    nVec++; if (bus.glitchErr !== 1'b0 || bus.overflowErr !== 1'b0) begin nErr++; $display("FAIL lb8_errs got %b%b want 00", bus.glitchErr, bus.overflowErr); end
  endtask

  task automatic test_rgb32();
    logic [7:0] expA [3];
    logic [7:0] expD [3];
    expA[0] = 8'd1; expD[0] = 8'h34;
    expA[1] = 8'd0; expD[1] = 8'h12;
    expA[2] = 8'd2; expD[2] = 8'h56;
    clearLog(); regCtrl32bit = 1'b1;
    sendWire(grbWire(8'h34, 8'h12, 8'h56), 24);
    regCtrl32bit = 1'b0;
    latchLow();
    nVec++; if (wrAddr.size() !== 3) begin nErr++; $display("FAIL rgb32_writes got %0d want 3", wrAddr.size()); end
    for (int i = 0; i < 3 && i < wrAddr.size(); i++) begin
      nVec++;
      if (wrAddr[i] !== expA[i] || wrData[i] !== expD[i]) begin
        nErr++; $display("FAIL rgb32_write%0d got %h:%h want %h:%h", i, wrAddr[i], wrData[i], expA[i], expD[i]);
      end
    end
    nVec++; if (fdCount !== 1 || lastCount !== 8'd1) begin nErr++; $display("FAIL rgb32_frame got %0d/%0d want 1/1", fdCount, lastCount); end
  endtask

  task automatic test_partial();
    clearLog();
    sendWire(packedWire(8'h00), 10);
    latchLow();
    nVec++; if (wrAddr.size() !== 0) begin nErr++; $display("FAIL partial_writes got %0d want 0", wrAddr.size()); end
    nVec++; if (fdCount !== 1 || lastCount !== 8'd0) begin nErr++; $display("FAIL partial_frame got %0d/%0d want 1/0", fdCount, lastCount); end
    clearLog();
    sendWire(packedWire(8'h5A), 24);
    latchLow();
    nVec++;
    if (wrAddr.size() !== 1 || wrAddr[0] !== 8'd0 || wrData[0] !== 8'h5A) begin
      nErr++; $display("FAIL partial_next got %0d writes want 1 write 00:5a", wrAddr.size());
    end
    nVec++; if (lastCount !== 8'd1) begin nErr++; $display("FAIL partial_nextCount got %0d want 1", lastCount); end
  endtask

  task automatic test_long_high();
    clearLog();
    sendWire(packedWire(8'hC3), 24);
    sendWire(packedWire(8'h00), 5);
    drive(1'b1, 12);
    drive(1'b0, 3);
    sendWire(packedWire(8'h81), 24);
    latchLow();
    nVec++;
    if (wrAddr.size() !== 1 || wrData[0] !== 8'hC3) begin
      nErr++; $display("FAIL longhigh_writes got %0d writes want 1 write c3", wrAddr.size());
    end
    nVec++; if (bus.glitchErr !== 1'b1) begin nErr++; $display("FAIL longhigh_glitchErr got %b want 1", bus.glitchErr); end
    nVec++; if (fdCount !== 0) begin nErr++; $display("FAIL longhigh_frameDone got %0d want 0", fdCount); end
    clearLog();
    sendWire(packedWire(8'h7E), 24);
    latchLow();
    nVec++; if (bus.glitchErr !== 1'b0) begin nErr++; $display("FAIL longhigh_clear got %b want 0", bus.glitchErr); end
    nVec++;
    if (wrAddr.size() !== 1 || wrData[0] !== 8'h7E || fdCount !== 1) begin
      nErr++; $display("FAIL longhigh_recover got %0d writes %0d frames want 1/1", wrAddr.size(), fdCount);
    end
  endtask

  task automatic test_overflow();
    clearLog(); regCtrl32bit = 1'b0;
    for (int p = 0; p < 6; p++) sendWire(packedWire(8'h10 + 8'(p)), 24);
    latchLow();
    nVec++; if (sAddr.size() !== 4) begin nErr++; $display("FAIL ovf_writes got %0d want 4", sAddr.size()); end
    for (int i = 0; i < 4 && i < sAddr.size(); i++) begin
      nVec++;
      if (sAddr[i] !== 2'(i) || sData[i] !== 8'h10 + 8'(i)) begin
        nErr++; $display("FAIL ovf_write%0d got %h:%h want %h:%h", i, sAddr[i], sData[i], 2'(i), 8'h10 + 8'(i));
      end
    end
    nVec++; if (busSmall.overflowErr !== 1'b1) begin nErr++; $display("FAIL ovf_flag got %b want 1", busSmall.overflowErr); end
    // pixelCount is BUFFER_BITS (2) wide here, so 6 pixels read back modulo 4
    nVec++; if (sFdCount !== 1 || sLastCount !== 2'd2) begin nErr++; $display("FAIL ovf_frame got %0d/%0d want 1/2", sFdCount, sLastCount); end
    nVec++;
    if (wrAddr.size() !== 6 || lastCount !== 8'd6 || bus.overflowErr !== 1'b0) begin
      nErr++; $display("FAIL ovf_bigBuffer got %0d writes count %0d ovf %b want 6/6/0", wrAddr.size(), lastCount, bus.overflowErr);
    end
  endtask

  task automatic test_run();
    clearLog();
    sendWire(packedWire(8'hAA), 12);
    regCtrlRun = 1'b0;
    tick(4);
    regCtrlRun = 1'b1;
    sendWire(packedWire(8'hAA), 24);
    latchLow();
    nVec++; if (wrAddr.size() !== 0) begin nErr++; $display("FAIL run_writes got %0d want 0", wrAddr.size()); end
    nVec++; if (fdCount !== 0) begin nErr++; $display("FAIL run_frameDone got %0d want 0", fdCount); end
  endtask

  task automatic test_resync();
    clearLog();
    sendWire(packedWire(8'hFF), 8);
    neoDataIn = 1'b1;
    syncReset = 1'b1;
    tick(1);
    syncReset = 1'b0;
    nVec++; if (bus.pixelCount !== 8'h00) begin nErr++; $display("FAIL resync_count got %h want 00", bus.pixelCount); end
    drive(1'b1, 4);
    drive(1'b0, 3);
    sendWire(packedWire(8'hFF), 24);
    sendWire(packedWire(8'h00), 6);
    latchLow();
    nVec++; if (wrAddr.size() !== 0 || fdCount !== 0) begin nErr++; $display("FAIL resync_quiet got %0d writes %0d frames want 0/0", wrAddr.size(), fdCount); end
    clearLog();
    sendWire(packedWire(8'h99), 24);
    latchLow();
    nVec++;
    if (wrAddr.size() !== 1 || wrData[0] !== 8'h99 || lastCount !== 8'd1) begin
      nErr++; $display("FAIL resync_next got %0d writes count %0d want 1 write 99 count 1", wrAddr.size(), lastCount);
    end
  endtask

`ifdef NEOPIXEL_DECODER_GLITCH_FILTER_EN
  task automatic test_spike();
    logic [23:0] rv;
    clearLog();
    rv = packedWire(8'h24);
    for (int k = 0; k < 24; k++) begin
      if (!rv[k]) begin
        drive(1'b1, 2); drive(1'b0, 3); drive(1'b1, 1); drive(1'b0, 3);
      end else begin
        sendBit(1'b1);
      end
    end
    latchLow();
    nVec++;
    if (wrAddr.size() !== 1 || wrData[0] !== 8'h24 || lastCount !== 8'd1) begin
      nErr++; $display("FAIL spike_filter got %0d writes count %0d want 1 write 24 count 1", wrAddr.size(), lastCount);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_loopback8();
    test_rgb32();
    test_partial();
    test_long_high();
    test_overflow();
    test_run();
    test_resync();
`ifdef NEOPIXEL_DECODER_GLITCH_FILTER_EN
    test_spike();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
